pipelined_adder: RTL and testbench

Parametrised, pipelined add/subtract unit with a valid/ready stream handshake. WIDTH-bit operands are split into STAGES equal carry segments; one segment is resolved per pipeline stage, so the unit sustains one operation per clock at wide widths. It supersedes the single-cycle combinational 16-bit adder in datapaths that need registered, flow-controlled arithmetic, such as accumulators and address generators.

---
 rtl/pipelined_adder.sv | 93 +++++++++
 tb/tb_pipelined_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Segmented-carry add/subtract pipeline with valid/ready flow control.
// Level 0 registers the operands; level k resolves carry segment k-1.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy
);

    localparam int SEG = WIDTH / STAGES;

    logic [STAGES:0]  r_vld;
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES+1];
    logic             r_c [STAGES+1];
    logic             r_ovf;

    logic [WIDTH-1:0] w_s [1:STAGES];
    logic             w_c [1:STAGES];
    logic [SEG:0]     w_sum;
    logic             w_ovf;
    logic             w_stall;

    assign w_stall  = r_vld[STAGES] && !OutReady;
    assign InReady  = !w_stall;
    assign S        = r_s[STAGES];
    assign Cout     = r_c[STAGES];
    assign Ovf      = r_ovf;
    assign OutValid = r_vld[STAGES];
    assign Busy     = |r_vld;

    // Each level adds its own segment and carries resolved bits forward.
    always_comb begin
        w_sum = '0;
        for (int k = 1; k <= STAGES; k++) begin
            w_sum = {1'b0, r_a[k-1][(k-1)*SEG +: SEG]}
                  + {1'b0, r_b[k-1][(k-1)*SEG +: SEG]}
                  + {{SEG{1'b0}}, r_c[k-1]};
            w_s[k] = r_s[k-1];
            w_s[k][(k-1)*SEG +: SEG] = w_sum[SEG-1:0];
            w_c[k] = w_sum[SEG];
        end
        w_ovf = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1]
              ^ w_s[STAGES][WIDTH-1] ^ w_c[STAGES];
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_vld <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_vld <= {r_vld[STAGES-1:0], InValid};
            if (InValid) begin
                r_a[0] <= A;
                r_b[0] <= Sub ? ~B : B;
                r_c[0] <= Cin ^ Sub;
                r_s[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            for (int k = 1; k <= STAGES; k++) begin
                r_s[k] <= w_s[k];
                r_c[k] <= w_c[k];
            end
            r_ovf <= w_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed checks of pipelined_adder against an
// arithmetic reference model with an in-order scoreboard.
module tb_pipelined_adder;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        Sub = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [15:0] S;
    logic        Cout;
    logic        Ovf;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic        Busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_in = 0;
    int          n_out = 0;
    logic [17:0] q[$];

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .Clk(Clk), .Resetn(Resetn), .A(A), .B(B), .Cin(Cin),
        .Sub(Sub), .InValid(InValid), .InReady(InReady), .S(S),
        .Cout(Cout), .Ovf(Ovf), .OutValid(OutValid),
        .OutReady(OutReady), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {Ovf, Cout, S} from plain signed/unsigned arithmetic
    function automatic logic [17:0] model(input logic [15:0] a,
        input logic [15:0] b, input logic c, input logic s);
        int          sa;
        int          sb;
        int          r;
        int          u;
        logic [31:0] uv;
        logic        ov;
        sa = $signed(a);
        sb = $signed(b);
        if (!s) begin
            u = int'(a) + int'(b) + int'(c);
            r = sa + sb + int'(c);
        end else begin
            u = 65536 + int'(a) - int'(b) - int'(c);
            r = sa - sb - int'(c);
        end
        uv = u;
        ov = (r > 32767) || (r < -32768);
        return {ov, uv[16], uv[15:0]};
    endfunction

    task automatic cyc();
        logic [17:0] e;
        @(negedge Clk);
        if (OutValid && OutReady) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(OutValid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("result", {14'd0, Ovf, Cout, S}, {14'd0, e});
            end
            n_out++;
        end
        if (InValid && InReady) begin
            q.push_back(model(A, B, Cin, Sub));
            n_in++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic dir(input string tag, input logic [15:0] a,
        input logic [15:0] b, input logic c, input logic s,
        input logic [15:0] es, input logic ec, input logic eo);
        A = a; B = b; Cin = c; Sub = s; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_early"}, 32'(OutValid), 32'd0);
            @(posedge Clk);
            #1;
        end
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({tag, "_s"}, 32'(S), 32'(es));
        chk({tag, "_cout"}, 32'(Cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(Ovf), 32'(eo));
        @(posedge Clk);
        #1;
        chk({tag, "_gone"}, 32'(OutValid), 32'd0);
    endtask

    initial begin
        logic [17:0] hold;
        int          cycles;
        #2;
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ready", 32'(InReady), 32'd1);
        #20;
        Resetn = 1'b1;
        @(posedge Clk);
        #1;

        dir("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        dir("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("subb", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        dir("sneg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // mid-flight reset discards tokens
        for (int i = 0; i < 3; i++) begin
            A = 16'(i + 1); B = 16'h1111; Cin = 1'b0; Sub = 1'b0;
            InValid = 1'b1;
            cyc();
        end
        InValid = 1'b0;
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(OutValid), 32'd0);
        chk("mid_rst_s", 32'(S), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_ready", 32'(InReady), 32'd1);
        q.delete();
        #4;
        Resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("no_stale", 32'(OutValid), 32'd0);
            cyc();
        end

        // backpressure
        OutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = 16'h1000 * 16'(i); B = 16'h0123; Cin = 1'b1;
            Sub = 1'(i);
            InValid = 1'b1;
            cyc();
        end
        InValid = 1'b0;
        cyc();
        hold = q[0];
        A = 16'hAAAA; B = 16'h5555; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(InReady), 32'd0);
            chk("bp_valid", 32'(OutValid), 32'd1);
            chk("bp_s", 32'(S), 32'(hold[15:0]));
            cyc();
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        chk("bp_qlen", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_seq", 32'(OutValid), 32'd1);
            cyc();
        end
        chk("bp_drained", 32'(OutValid), 32'd0);

        // random stream
        n_in = 0;
        n_out = 0;
        cycles = 0;
        while (n_in < 200 && cycles < 4000) begin
            A = 16'($urandom);
            B = 16'($urandom);
            Cin = 1'($urandom);
            Sub = 1'($urandom);
            InValid = 1'($urandom);
            OutReady = 1'($urandom);
            cyc();
            cycles++;
        end
        chk("rnd_accepted", 32'(n_in), 32'd200);
        InValid = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 12; i++) cyc();
        chk("rnd_count", 32'(n_out), 32'(n_in));
        chk("rnd_qempty", 32'(q.size()), 32'd0);
        chk("end_busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
